// File: rtl/match_cnt_pkg.sv
// Shared constants and types for the match_counter_n timer/event-count primitive.
// Direction constants and the next-count select encoding used by the top level.
package match_cnt_pkg;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_LOAD = 3'd1,
        SEL_CLR  = 3'd2,
        SEL_INC  = 3'd3,
        SEL_DEC  = 3'd4
    } sel_e;

    // True when the selected step crosses the natural 2^WIDTH boundary.
    function automatic logic is_wrap(sel_e sel, logic at_max, logic at_min);
        return ((sel == SEL_INC) && at_max) || ((sel == SEL_DEC) && at_min);
    endfunction

endpackage

// File: rtl/match_cnt_cmp.sv
// One compare channel of match_counter_n: registered pulse when the next count
// equals this channel's compare value and the counter actually updates.
module match_cnt_cmp
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic [WIDTH-1:0] count_next,
    input  logic [WIDTH-1:0] match_val,
    output logic             match_pulse
);

    logic hit;

    assign hit = update && (count_next == match_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= hit;
        end
    end

endmodule

// File: rtl/match_counter_n.sv
// Parametrised up/down counter with NUM_MATCH compare channels, load, period mode
// and wrap reporting. Define MATCH_CNT_PRESCALE_EN to add the prescale port/divider.
module match_counter_n
    import match_cnt_pkg::*;
#(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned NUM_MATCH  = 2,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_val,
    input  logic                      clear_on_match,
    input  logic [NUM_MATCH*WIDTH-1:0] match_in,
`ifdef MATCH_CNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]     prescale,
`endif
    output logic [WIDTH-1:0]          count,
    output logic [NUM_MATCH-1:0]      match_out,
    output logic                      wrap
);

    if (WIDTH < 2 || NUM_MATCH < 1 || PRESCALE_W < 1) begin : g_param_err
        $error("match_counter_n: invalid parameters");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] period;
    logic             tick;
    logic             step;
    logic             update;
    logic             wrap_q;
    logic             wrap_d;
    sel_e             sel;

    assign period = match_in[WIDTH-1:0];

`ifdef MATCH_CNT_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_q;
    logic [PRESCALE_W-1:0] psc_d;

    assign tick = (psc_q == prescale);

    // Load realigns the divider so the first step after a load is a full period.
    always_comb begin
        psc_d = psc_q;
        if (load) begin
            psc_d = '0;
        end else if (en) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign step = en && tick;

    always_comb begin
        sel = SEL_HOLD;
        if (load) begin
            sel = SEL_LOAD;
        end else if (step && clear_on_match && (count_q == period)) begin
            sel = SEL_CLR;
        end else if (step && (up_dn == UP)) begin
            sel = SEL_INC;
        end else if (step) begin
            sel = SEL_DEC;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case (sel)
            SEL_LOAD: count_d = load_val;
            SEL_CLR:  count_d = '0;
            SEL_INC:  count_d = count_q + 1'b1;
            SEL_DEC:  count_d = count_q - 1'b1;
            default:  count_d = count_q;
        endcase
    end

    assign update = (sel != SEL_HOLD);
    assign wrap_d = is_wrap(sel, count_q == '1, count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

    for (genvar i = 0; i < NUM_MATCH; i++) begin : g_ch
        match_cnt_cmp #(
            .WIDTH(WIDTH)
        ) u_cmp (
            .clk        (clk),
            .rst        (rst),
            .update     (update),
            .count_next (count_d),
            .match_val  (match_in[i*WIDTH +: WIDTH]),
            .match_pulse(match_out[i])
        );
    end

endmodule

// File: tb/tb_match_counter_n.sv
// Scoreboard bench for match_counter_n (WIDTH=5, NUM_MATCH=2, 25 MHz clock).
// A behavioural model pushes expected outputs per cycle; they are popped after the edge.
module tb_match_counter_n;

    localparam int unsigned W  = 5;
    localparam int unsigned N  = 2;
    localparam int unsigned PW = 4;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic [N-1:0] mt;
        logic         wr;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           up_dn;
    logic           load;
    logic [W-1:0]   load_val;
    logic           clear_on_match;
    logic [N*W-1:0] match_in;
    logic [PW-1:0]  prescale;
    logic [W-1:0]   count;
    logic [N-1:0]   match_out;
    logic           wrap;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t         sb_q[$];
    logic [W-1:0] m_cnt;
    logic [PW-1:0] m_psc;

    always #20 clk = ~clk;

    match_counter_n #(
        .WIDTH     (W),
        .NUM_MATCH (N),
        .PRESCALE_W(PW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .up_dn         (up_dn),
        .load          (load),
        .load_val      (load_val),
        .clear_on_match(clear_on_match),
        .match_in      (match_in),
`ifdef MATCH_CNT_PRESCALE_EN
        .prescale      (prescale),
`endif
        .count         (count),
        .match_out     (match_out),
        .wrap          (wrap)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ch(input int i);
        return match_in[i*W +: W];
    endfunction

    task automatic set_ch(input int i, input logic [W-1:0] v);
        match_in[i*W +: W] = v;
    endtask

    function automatic exp_t model_step();
        exp_t         e;
        logic [W-1:0] nxt;
        logic         upd;
        logic         tk;
        nxt  = m_cnt;
        upd  = 1'b0;
        e.wr = 1'b0;
`ifdef MATCH_CNT_PRESCALE_EN
        tk = (m_psc == prescale);
        if (load) m_psc = '0;
        else if (en) m_psc = tk ? '0 : m_psc + 1'b1;
`else
        tk = 1'b1;
`endif
        if (load) begin
            nxt = load_val;
            upd = 1'b1;
        end else if (en && tk) begin
            upd = 1'b1;
            if (clear_on_match && m_cnt == ch(0)) begin
                nxt = '0;
            end else if (up_dn) begin
                nxt  = m_cnt + 1'b1;
                e.wr = (m_cnt == 5'd31);
            end else begin
                nxt  = m_cnt - 1'b1;
                e.wr = (m_cnt == 5'd0);
            end
        end
        for (int i = 0; i < N; i++) e.mt[i] = upd && (nxt == ch(i));
        e.cnt = nxt;
        m_cnt = nxt;
        return e;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        sb_q.push_back(model_step());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("count", 32'(count), 32'(e.cnt));
            check_eq("match_out", 32'(match_out), 32'(e.mt));
            check_eq("wrap", 32'(wrap), 32'(e.wr));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        clear_on_match = 1'b0; match_in = '0; prescale = '0;
        m_cnt = '0; m_psc = '0;

        // 1: reset, then free-running up count through a wrap
        #25;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_match", 32'(match_out), 32'd0);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        #5;
        rst = 1'b0;
        en = 1'b1; up_dn = 1'b1; set_ch(0, 5'd4); set_ch(1, 5'd20);
        repeat (34) step();

        // 2: period mode with ch0=4
        load = 1'b1; load_val = 5'd0;
        step();
        load = 1'b0; clear_on_match = 1'b1;
        repeat (12) step();

        // 3: load 2 then count down through 0 -> 31
        clear_on_match = 1'b0; set_ch(0, 5'd10); set_ch(1, 5'd31);
        load = 1'b1; load_val = 5'd2;
        step();
        load = 1'b0; up_dn = 1'b0;
        repeat (4) step();

        // 4: load wins over a period-mode clear
        up_dn = 1'b1; clear_on_match = 1'b1; set_ch(0, 5'd4);
        load = 1'b1; load_val = 5'd3;
        step();
        load = 1'b0;
        step();
        load = 1'b1; load_val = 5'd7; set_ch(1, 5'd7);
        step();
        load = 1'b0;

        // 5: hold at the match value produces no repeated pulse
        clear_on_match = 1'b0;
        load = 1'b1; load_val = 5'd3;
        step();
        load = 1'b0;
        step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;

        // 6: asynchronous reset mid-count
        repeat (3) step();
        #4;
        rst = 1'b1;
        #1;
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_match", 32'(match_out), 32'd0);
        check_eq("arst_wrap", 32'(wrap), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = '0; m_psc = '0;
        @(posedge clk);
        #1;
        check_eq("post_rst_hold", 32'(count), 32'd0);
        en = 1'b1;
`ifdef MATCH_CNT_PRESCALE_EN
        prescale = 4'd3;
        repeat (12) step();
        prescale = 4'd0;
`endif
        repeat (6) step();

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
